// File: rtl/psum_line_accumulator_pkg.sv
// Shared definitions for the partial-sum line accumulator: default widths, FSM states,
// control-register bit positions and the output saturation helper.
package psum_line_accumulator_pkg;

  localparam int unsigned DefBitWidth  = 8;
  localparam int unsigned DefNumKernel = 4;
  localparam int unsigned DefRegWidth  = 32;

  typedef enum logic [0:0] {
    StIdle,
    StAccum
  } state_e;

  localparam int unsigned CtrlEnBit  = 0;
  localparam int unsigned CtrlClrBit = 1;

  // Clamp a signed value into the range of a w-bit two's complement number.
  function automatic logic signed [31:0] saturate(input logic signed [31:0] v,
                                                  input int unsigned w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/psum_line_accumulator_if.sv
// Partial-sum input lanes and the finished-pixel output stream of the line accumulator.
interface psum_line_accumulator_if
  import psum_line_accumulator_pkg::*;
#(
  parameter int unsigned BIT_WIDTH  = DefBitWidth,
  parameter int unsigned NUM_KERNEL = DefNumKernel
);

  logic [BIT_WIDTH-1:0]            psum_kn0;
  logic [BIT_WIDTH-1:0]            psum_kn1;
  logic [BIT_WIDTH-1:0]            psum_kn2;
  logic [BIT_WIDTH-1:0]            psum_kn3;
  logic                            psum_kn0_val;
  logic                            psum_kn1_val;
  logic                            psum_kn2_val;
  logic                            psum_kn3_val;
  logic [BIT_WIDTH*NUM_KERNEL-1:0] data;
  logic                            data_val;
  logic                            data_ready;

  modport master (
    output psum_kn0, psum_kn1, psum_kn2, psum_kn3,
    output psum_kn0_val, psum_kn1_val, psum_kn2_val, psum_kn3_val,
    input  data, data_val,
    output data_ready
  );

  modport slave (
    input  psum_kn0, psum_kn1, psum_kn2, psum_kn3,
    input  psum_kn0_val, psum_kn1_val, psum_kn2_val, psum_kn3_val,
    output data, data_val,
    input  data_ready
  );

endinterface

// File: rtl/psum_out_fifo.sv
// Small synchronous first-word-fall-through FIFO with occupancy count and drop indication.
module psum_out_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrWidth = $clog2(DEPTH),
  localparam int unsigned CntWidth = PtrWidth + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                push,
  input  logic [WIDTH-1:0]    push_data,
  input  logic                pop,
  output logic [WIDTH-1:0]    data,
  output logic                data_val,
  output logic [CntWidth-1:0] count,
  output logic                drop
);

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntWidth-1:0] count_q, count_d;
  logic                empty, full, wr_en, rd_en;

  assign empty = (count_q == '0);
  assign full  = (count_q == CntWidth'(DEPTH));
  assign rd_en = pop && !empty;
  // A full FIFO still accepts when an entry leaves in the same cycle.
  assign wr_en = push && (!full || rd_en);
  assign drop  = push && full && !rd_en;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PtrWidth'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + PtrWidth'(1);
      count_d = count_q + CntWidth'(wr_en) - CntWidth'(rd_en);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !clear) mem_q[wr_ptr_q] <= push_data;
  end

  assign data     = empty ? '0 : mem_q[rd_ptr_q];
  assign data_val = !empty;
  assign count    = count_q;

endmodule

// File: rtl/psum_line_accumulator.sv
// Accumulates four kernel partial-sum lanes across several passes over an output line and
// emits saturated pixels through a small output FIFO.
module psum_line_accumulator
  import psum_line_accumulator_pkg::*;
#(
  parameter int unsigned BIT_WIDTH  = DefBitWidth,
  parameter int unsigned NUM_KERNEL = DefNumKernel,
  parameter int unsigned ACC_WIDTH  = 20,
  parameter int unsigned LINE_DEPTH = 64,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned REG_WIDTH  = DefRegWidth
) (
  input  logic                   clk,
  input  logic                   rst,
  psum_line_accumulator_if.slave bus,
  input  logic [REG_WIDTH-1:0]   i_conf_ctrl,
  input  logic [REG_WIDTH-1:0]   i_conf_linewidth,
  input  logic [REG_WIDTH-1:0]   i_conf_passnum,
  output logic                   o_stall,
  output logic                   o_line_done,
  output logic                   o_err_lane,
  output logic                   o_err_drop
);

  localparam int unsigned OutWidth  = BIT_WIDTH * NUM_KERNEL;
  localparam int unsigned CntWidth  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned PassWidth = 8;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  col_q, col_d;
  logic [PassWidth-1:0]   pass_q, pass_d;
  logic [ADDR_WIDTH:0]    lw_q, lw_d;
  logic [PassWidth-1:0]   pn_q, pn_d;
  logic                   err_lane_q, err_lane_d;
  logic                   err_drop_q, err_drop_d;
  logic                   line_done_q, line_done_d;

  logic                   en, clr, leave, beat, lane_err, push;
  logic                   last_col, last_pass;
  logic [NUM_KERNEL-1:0]  lane_val;
  logic                   unused_conf;

  logic signed [BIT_WIDTH-1:0] psum     [NUM_KERNEL];
  logic        [ACC_WIDTH-1:0] psum_ext [NUM_KERNEL];
  logic        [ACC_WIDTH-1:0] base     [NUM_KERNEL];
  logic signed [ACC_WIDTH-1:0] sum      [NUM_KERNEL];
  logic signed [ACC_WIDTH-1:0] acc_q    [NUM_KERNEL][LINE_DEPTH];
  logic        [OutWidth-1:0]  push_data;

  logic [CntWidth-1:0]    fifo_count;
  logic                   fifo_drop;

  assign en  = i_conf_ctrl[CtrlEnBit];
  assign clr = i_conf_ctrl[CtrlClrBit];
  assign unused_conf = ^{i_conf_ctrl[REG_WIDTH-1:2], i_conf_linewidth[REG_WIDTH-1:ADDR_WIDTH+1],
                         i_conf_passnum[REG_WIDTH-1:PassWidth]};

  assign psum[0]  = bus.psum_kn0;
  assign psum[1]  = bus.psum_kn1;
  assign psum[2]  = bus.psum_kn2;
  assign psum[3]  = bus.psum_kn3;
  assign lane_val = {bus.psum_kn3_val, bus.psum_kn2_val, bus.psum_kn1_val, bus.psum_kn0_val};

  assign last_col  = ({1'b0, col_q} == lw_q - (ADDR_WIDTH + 1)'(1));
  assign last_pass = (pass_q == pn_q - PassWidth'(1));

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  // Next-state logic; soft clear overrides everything.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (en) state_d = StAccum;
      StAccum: if (leave) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (clr) state_d = StIdle;
  end

  // Decoded controls: a line may only be left at its start boundary.
  always_comb begin
    leave       = (state_q == StAccum) && !en && (col_q == '0) && (pass_q == '0);
    beat        = (state_q == StAccum) && !clr && !leave && (&lane_val);
    lane_err    = (state_q == StAccum) && !clr && (|lane_val) && !(&lane_val);
    push        = beat && last_pass;
    line_done_d = beat && last_col && last_pass;
  end

  always_comb begin
    col_d = col_q;
    pass_d = pass_q;
    lw_d = lw_q;
    pn_d = pn_q;
    if (clr) begin
      col_d  = '0;
      pass_d = '0;
    end else if (state_q == StIdle && en) begin
      lw_d   = i_conf_linewidth[ADDR_WIDTH:0];
      pn_d   = i_conf_passnum[PassWidth-1:0];
      col_d  = '0;
      pass_d = '0;
    end else if (beat) begin
      if (last_col) begin
        col_d  = '0;
        pass_d = last_pass ? '0 : pass_q + PassWidth'(1);
      end else begin
        col_d = col_q + ADDR_WIDTH'(1);
      end
    end
  end

  assign err_lane_d = clr ? 1'b0 : (err_lane_q | lane_err);
  assign err_drop_d = clr ? 1'b0 : (err_drop_q | fifo_drop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q       <= '0;
      pass_q      <= '0;
      lw_q        <= '0;
      pn_q        <= '0;
      err_lane_q  <= 1'b0;
      err_drop_q  <= 1'b0;
      line_done_q <= 1'b0;
    end else begin
      col_q       <= col_d;
      pass_q      <= pass_d;
      lw_q        <= lw_d;
      pn_q        <= pn_d;
      err_lane_q  <= err_lane_d;
      err_drop_q  <= err_drop_d;
      line_done_q <= line_done_d;
    end
  end

  // Pass 0 ignores stale contents, so the array never needs clearing.
  always_comb begin
    push_data = '0;
    for (int k = 0; k < NUM_KERNEL; k++) begin
      psum_ext[k] = {{(ACC_WIDTH - BIT_WIDTH){psum[k][BIT_WIDTH-1]}}, psum[k]};
      base[k]     = (pass_q == '0) ? '0 : acc_q[k][col_q];
      sum[k]      = base[k] + psum_ext[k];
      push_data[k*BIT_WIDTH +: BIT_WIDTH] =
          BIT_WIDTH'(saturate({{(32 - ACC_WIDTH){sum[k][ACC_WIDTH-1]}}, sum[k]}, BIT_WIDTH));
    end
  end

  always_ff @(posedge clk) begin
    if (beat) begin
      for (int k = 0; k < NUM_KERNEL; k++) acc_q[k][col_q] <= sum[k];
    end
  end

  psum_out_fifo #(
    .WIDTH (OutWidth),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (clr),
    .push      (push),
    .push_data (push_data),
    .pop       (bus.data_ready),
    .data      (bus.data),
    .data_val  (bus.data_val),
    .count     (fifo_count),
    .drop      (fifo_drop)
  );

  // One entry of headroom absorbs the beat already in flight when stall rises.
  assign o_stall     = (fifo_count >= CntWidth'(FIFO_DEPTH - 1));
  assign o_line_done = line_done_q;
  assign o_err_lane  = err_lane_q;
  assign o_err_drop  = err_drop_q;

endmodule

// File: tb/tb_psum_line_accumulator.sv
// Directed bench for psum_line_accumulator with a queue-based behavioural model checked
// every cycle, plus literal expectations for each scenario.
module tb_psum_line_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ctrl, lwidth, passnum;
  logic        o_stall, o_line_done, o_err_lane, o_err_drop;

  int checks = 0;
  int errors = 0;

  psum_line_accumulator_if #(.BIT_WIDTH(8), .NUM_KERNEL(4)) bus ();

  psum_line_accumulator dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus),
    .i_conf_ctrl      (ctrl),
    .i_conf_linewidth (lwidth),
    .i_conf_passnum   (passnum),
    .o_stall          (o_stall),
    .o_line_done      (o_line_done),
    .o_err_lane       (o_err_lane),
    .o_err_drop       (o_err_drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_accum;
  int          m_col, m_pass, m_lw, m_pn;
  int          m_acc [4][64];
  logic [31:0] m_q[$];
  bit          m_done, m_elane, m_edrop;

  function automatic int wrap_acc(input int x);
    logic [19:0] t;
    t = x[19:0];
    return int'($signed(t));
  endfunction

  always @(posedge clk or negedge rst) begin
    int          p [4];
    logic [3:0]  v;
    logic [31:0] w;
    int          s, c;
    if (!rst) begin
      m_accum = 0; m_col = 0; m_pass = 0; m_q.delete();
      m_done = 0; m_elane = 0; m_edrop = 0;
    end else begin
      m_done = 0;
      p[0] = $signed(bus.psum_kn0); p[1] = $signed(bus.psum_kn1);
      p[2] = $signed(bus.psum_kn2); p[3] = $signed(bus.psum_kn3);
      v = {bus.psum_kn3_val, bus.psum_kn2_val, bus.psum_kn1_val, bus.psum_kn0_val};
      if (m_q.size() > 0 && bus.data_ready) void'(m_q.pop_front());
      if (ctrl[1]) begin
        m_accum = 0; m_col = 0; m_pass = 0; m_q.delete(); m_elane = 0; m_edrop = 0;
      end else if (!m_accum) begin
        if (ctrl[0]) begin
          m_accum = 1; m_lw = int'(lwidth); m_pn = int'(passnum[7:0]); m_col = 0; m_pass = 0;
        end
      end else if (!ctrl[0] && m_col == 0 && m_pass == 0) begin
        m_accum = 0;
      end else if (v == 4'hF) begin
        w = '0;
        for (int k = 0; k < 4; k++) begin
          s = wrap_acc((m_pass == 0 ? 0 : m_acc[k][m_col]) + p[k]);
          m_acc[k][m_col] = s;
          c = (s > 127) ? 127 : (s < -128) ? -128 : s;
          w[k*8 +: 8] = 8'(c);
        end
        if (m_pass == m_pn - 1) begin
          if (m_q.size() < 4) m_q.push_back(w);
          else m_edrop = 1;
        end
        m_col++;
        if (m_col == m_lw) begin
          m_col = 0;
          m_pass++;
          if (m_pass == m_pn) begin
            m_pass = 0;
            m_done = 1;
          end
        end
      end else if (v != 4'h0) begin
        m_elane = 1;
      end
    end
  end

  // ---------------- per-cycle compare and output capture ----------------
  logic [31:0] got[$];
  int          done_cnt;

  always @(negedge clk) begin
    if (rst) begin
      check("data_val", 32'(bus.data_val), 32'(m_q.size() > 0));
      if (m_q.size() > 0) check("data", bus.data, m_q[0]);
      check("stall", 32'(o_stall), 32'(m_q.size() >= 3));
      check("line_done", 32'(o_line_done), 32'(m_done));
      check("err_lane", 32'(o_err_lane), 32'(m_elane));
      check("err_drop", 32'(o_err_drop), 32'(m_edrop));
      if (bus.data_val && bus.data_ready) got.push_back(bus.data);
      if (o_line_done) done_cnt++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input int p0, input int p1, input int p2, input int p3,
                       input logic [3:0] v);
    @(posedge clk); #1;
    bus.psum_kn0 = 8'(p0); bus.psum_kn1 = 8'(p1);
    bus.psum_kn2 = 8'(p2); bus.psum_kn3 = 8'(p3);
    {bus.psum_kn3_val, bus.psum_kn2_val, bus.psum_kn1_val, bus.psum_kn0_val} = v;
  endtask

  task automatic start(input int lw, input int pn);
    @(posedge clk); #1;
    ctrl = 32'd2;
    {bus.psum_kn3_val, bus.psum_kn2_val, bus.psum_kn1_val, bus.psum_kn0_val} = 4'h0;
    @(posedge clk); #1;
    ctrl = 32'd0; lwidth = 32'(lw); passnum = 32'(pn);
    got.delete(); done_cnt = 0;
    @(posedge clk); #1;
    ctrl = 32'd1;
  endtask

  task automatic check_got(input string name, input int idx, input logic [31:0] exp);
    check(name, (idx < got.size()) ? got[idx] : 32'hDEAD_BEEF, exp);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_data"}, bus.data, 32'h0);
    check({name, "_val"}, 32'(bus.data_val), 32'h0);
    check({name, "_stall"}, 32'(o_stall), 32'h0);
    check({name, "_done"}, 32'(o_line_done), 32'h0);
    check({name, "_elane"}, 32'(o_err_lane), 32'h0);
    check({name, "_edrop"}, 32'(o_err_drop), 32'h0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    ctrl = '0; lwidth = 32'd1; passnum = 32'd1;
    bus.psum_kn0 = '0; bus.psum_kn1 = '0; bus.psum_kn2 = '0; bus.psum_kn3 = '0;
    {bus.psum_kn3_val, bus.psum_kn2_val, bus.psum_kn1_val, bus.psum_kn0_val} = 4'h0;
    bus.data_ready = 1'b0;
    done_cnt = 0;
    #12;
    check_idle_outputs("reset");
    @(posedge clk); #3;
    rst = 1'b1;

    // Single pass, four pixels.
    bus.data_ready = 1'b1;
    start(4, 1);
    for (int i = 0; i < 4; i++) drive(1, 2, 3, 4, 4'hF);
    drive(0, 0, 0, 0, 4'h0);
    repeat (3) @(posedge clk);
    check("single_count", 32'(got.size()), 32'd4);
    for (int i = 0; i < 4; i++) check_got("single_data", i, 32'h0403_0201);
    check("single_done", 32'(done_cnt), 32'd1);

    // Three passes over a two-pixel line.
    start(2, 3);
    drive(10, 0, 0, 0, 4'hF); drive(20, 0, 0, 0, 4'hF); drive(30, 0, 0, 0, 4'hF);
    drive(40, 0, 0, 0, 4'hF); drive(50, 0, 0, 0, 4'hF);
    @(negedge clk);
    check("multi_early", 32'(got.size()), 32'd0);
    drive(60, 0, 0, 0, 4'hF);
    drive(0, 0, 0, 0, 4'h0);
    repeat (3) @(posedge clk);
    check("multi_count", 32'(got.size()), 32'd2);
    check_got("multi_px0", 0, 32'h0000_005A);
    check_got("multi_px1", 1, 32'h0000_0078);

    // Saturation, same column back to back.
    start(1, 3);
    for (int i = 0; i < 3; i++) drive(0, 100, -100, 0, 4'hF);
    drive(0, 0, 0, 0, 4'h0);
    repeat (3) @(posedge clk);
    check("sat_count", 32'(got.size()), 32'd1);
    check_got("sat_data", 0, 32'h0080_7F00);

    // Backpressure: four stored, four dropped.
    bus.data_ready = 1'b0;
    start(8, 1);
    for (int i = 1; i <= 4; i++) drive(i, 0, 0, 0, 4'hF);
    @(negedge clk);
    check("bp_stall", 32'(o_stall), 32'h1);
    for (int i = 5; i <= 8; i++) drive(i, 0, 0, 0, 4'hF);
    drive(0, 0, 0, 0, 4'h0);
    @(negedge clk);
    check("bp_drop", 32'(o_err_drop), 32'h1);
    check("bp_head", bus.data, 32'h0000_0001);
    @(posedge clk); #1;
    bus.data_ready = 1'b1;
    repeat (6) @(posedge clk);
    check("bp_count", 32'(got.size()), 32'd4);
    for (int i = 0; i < 4; i++) check_got("bp_order", i, 32'(i + 1));

    // Partial lane valids are discarded.
    start(2, 2);
    drive(50, 50, 50, 50, 4'b0111);
    drive(1, 0, 0, 0, 4'hF); drive(2, 0, 0, 0, 4'hF);
    drive(4, 0, 0, 0, 4'hF); drive(8, 0, 0, 0, 4'hF);
    drive(0, 0, 0, 0, 4'h0);
    repeat (3) @(posedge clk);
    check("lane_err", 32'(o_err_lane), 32'h1);
    check("lane_count", 32'(got.size()), 32'd2);
    check_got("lane_px0", 0, 32'h0000_0005);
    check_got("lane_px1", 1, 32'h0000_000A);

    // Asynchronous reset in the middle of a line.
    bus.data_ready = 1'b0;
    start(2, 2);
    drive(1, 0, 0, 0, 4'hF); drive(2, 0, 0, 0, 4'hF);
    drive(3, 0, 0, 0, 4'hF); drive(4, 0, 0, 0, 4'hF);
    drive(9, 9, 9, 9, 4'hF); drive(9, 9, 9, 9, 4'hF); drive(9, 9, 9, 9, 4'hF);
    drive(9, 9, 9, 9, 4'b0011);
    drive(0, 0, 0, 0, 4'h0);
    @(negedge clk);
    check("prerst_val", 32'(bus.data_val), 32'h1);
    check("prerst_data", bus.data, 32'h0000_0004);
    check("prerst_elane", 32'(o_err_lane), 32'h1);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    check_idle_outputs("midrst");
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    bus.data_ready = 1'b1;
    start(2, 2);
    drive(5, 0, 0, 0, 4'hF); drive(6, 0, 0, 0, 4'hF);
    drive(7, 0, 0, 0, 4'hF); drive(8, 0, 0, 0, 4'hF);
    drive(0, 0, 0, 0, 4'h0);
    repeat (3) @(posedge clk);
    check("postrst_count", 32'(got.size()), 32'd2);
    check_got("postrst_px0", 0, 32'h0000_000C);
    check_got("postrst_px1", 1, 32'h0000_000E);
    check("postrst_done", 32'(done_cnt), 32'd1);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
